mem_copy_engine: RTL

- Word-block copy initiator that drives the data-memory port: clock-edge write with `we`, combinational read data `rd`, word-aligned address `a[31:2]`.
- On `start`, copies `len` 32-bit words from `src` to `dst` by alternating read and write cycles.
- Reports `busy`, a one-cycle `done` pulse, an `err` flag and a committed-word count.
- Sits beside the multi-cycle core as the memory master during block moves; the core must not drive the port while `busy`=1.

---
 rtl/mem_copy_engine.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
`timescale 1ns/1ps
// Block-copy memory master: moves len words from src to dst through the single
// data-memory port, one read cycle followed by one write cycle per word.
module mem_copy_engine #(
   parameter int MEM_WORDS = 64,
   parameter int LEN_W     = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      src,
   input  logic [31:0]      dst,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [LEN_W-1:0] words_done,
   output logic             mem_we,
   output logic [31:0]      mem_a,
   output logic [31:0]      mem_wd,
   input  logic [31:0]      mem_rd
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [29:0]      sptr;
   logic [29:0]      dptr;
   logic [LEN_W-1:0] remaining;
   logic [31:0]      data_q;
   logic [30:0]      src_end;
   logic [30:0]      dst_end;
   logic             range_bad;
   logic             len_zero;
   logic             last_word;
   logic             unused_addr_lsbs;

   assign unused_addr_lsbs = ^{src[1:0], dst[1:0]};

   // One extra bit on the end-pointer sums keeps a huge base address from wrapping
   // back into range.
   assign src_end   = {1'b0, src[31:2]} + 31'(len);
   assign dst_end   = {1'b0, dst[31:2]} + 31'(len);
   assign range_bad = (src_end > 31'(MEM_WORDS)) || (dst_end > 31'(MEM_WORDS));
   assign len_zero  = (len == '0);
   assign last_word = (remaining == LEN_W'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (len_zero || range_bad) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = READ;
               end
            end
         end
         READ: begin
            if (abort) begin
               state_nxt = DONE;
            end else begin
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            if (abort || last_word) begin
               state_nxt = DONE;
            end else begin
               state_nxt = READ;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Memory strobes decode straight from state so an async reset drops mem_we at once.
   always_comb begin
      busy   = 1'b0;
      done   = 1'b0;
      mem_we = 1'b0;
      mem_a  = 32'd0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
         end
         READ: begin
            busy  = 1'b1;
            mem_a = {sptr, 2'b00};
         end
         WRITE: begin
            busy   = 1'b1;
            mem_we = 1'b1;
            mem_a  = {dptr, 2'b00};
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign mem_wd = data_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sptr       <= '0;
         dptr       <= '0;
         remaining  <= '0;
         data_q     <= '0;
         words_done <= '0;
         err        <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  sptr       <= src[31:2];
                  dptr       <= dst[31:2];
                  remaining  <= len;
                  words_done <= '0;
                  err        <= !len_zero && range_bad;
               end
            end
            READ: begin
               data_q <= mem_rd;
               if (abort) begin
                  err <= 1'b1;
               end
            end
            WRITE: begin
               words_done <= words_done + LEN_W'(1);
               sptr       <= sptr + 30'd1;
               dptr       <= dptr + 30'd1;
               remaining  <= remaining - LEN_W'(1);
               if (abort) begin
                  err <= 1'b1;
               end
            end
            DONE: begin
               err <= err;
            end
            default: begin
               err <= err;
            end
         endcase
      end
   end

endmodule
